// File: rtl/dut_host_sequencer.sv
// dut_host_sequencer
//
// Host-side initiator for the processor Start/Ack program handshake.
// Loads LOAD_LEN source words into data memory, pulses DutStart for START_CYC
// cycles, waits for DutAck while counting cycles (bounded by TIMEOUT), then
// streams RES_LEN words of data memory back out as results.
//
// Ports:
//   Clk, Reset            clock (posedge), synchronous active-low reset
//   Go                    begin a run (honoured in IDLE and DONE only)
//   SrcValid/SrcData/SrcReady   source stream feeding the load phase
//   HostSel/HostWrEn/HostAddr/HostWrData/HostRdData
//                         data-memory host port (owned while HostSel=1)
//   DutStart, DutAck      processor program handshake
//   ResValid/ResData/ResReady   result stream produced by the drain phase
//   Busy, Done            run status (Busy: not IDLE/DONE, Done: in DONE)
//   TimedOut              last run gave up waiting for DutAck
//   CycleCount            WAIT cycles seen with DutAck low in the last run
module dut_host_sequencer #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 64,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          SrcValid,
  input  logic [DW-1:0] SrcData,
  output logic          SrcReady,
  output logic          HostSel,
  output logic          HostWrEn,
  output logic [AW-1:0] HostAddr,
  output logic [DW-1:0] HostWrData,
  input  logic [DW-1:0] HostRdData,
  output logic          DutStart,
  input  logic          DutAck,
  output logic          ResValid,
  output logic [DW-1:0] ResData,
  input  logic          ResReady,
  output logic          Busy,
  output logic          Done,
  output logic          TimedOut,
  output logic [15:0]   CycleCount
);

  localparam int MAX_LEN = (LOAD_LEN > RES_LEN) ? LOAD_LEN : RES_LEN;
  localparam int IW      = $clog2(MAX_LEN + 1) + 1;

  // Last index of each phase; the zero-length encodings are never compared
  // because the corresponding state is skipped entirely.
  localparam logic [IW-1:0] LOAD_LAST  = IW'(LOAD_LEN - 1);
  localparam logic [IW-1:0] RES_LAST   = IW'(RES_LEN - 1);
  localparam logic [31:0]   START_LAST = 32'(START_CYC - 1);
  localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT - 1);
  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);
  localparam bit            HAS_LOAD   = (LOAD_LEN > 0);
  localparam bit            HAS_RES    = (RES_LEN > 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  // Phase counter: START pulse length, then WAIT cycles toward the timeout.
  // Kept separate from CycleCount so a TIMEOUT beyond 16 bits still works
  // while CycleCount saturates.
  logic [31:0]   cnt_q, cnt_d;
  logic [15:0]   cyc_q, cyc_d;
  logic          to_q, to_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Base + index, wrapping modulo 2^AW.
  function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base,
                                              input logic [IW-1:0] off);
    return base + AW'(off);
  endfunction

  // Next-state and counter updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Go) begin
          idx_d   = '0;
          cnt_d   = '0;
          cyc_d   = '0;
          to_d    = 1'b0;
          state_d = HAS_LOAD ? S_LOAD : S_START;
        end
      end
      S_LOAD: begin
        // SrcReady is 1 throughout LOAD, so SrcValid alone is the handshake.
        if (SrcValid) begin
          if (idx_q == LOAD_LAST) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          cyc_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (DutAck) begin
          idx_d   = '0;
          state_d = HAS_RES ? S_DRAIN : S_DONE;
        end else begin
          cyc_d = sat_inc16(cyc_q);
          if (cnt_q == TO_LAST) begin
            to_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_DRAIN: begin
        if (ResReady) begin
          if (idx_q == RES_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes from state; only LOAD write-through and DRAIN
  // read-through pass inputs straight to outputs.
  always_comb begin
    SrcReady   = 1'b0;
    HostSel    = 1'b0;
    HostWrEn   = 1'b0;
    HostAddr   = '0;
    HostWrData = '0;
    DutStart   = 1'b0;
    ResValid   = 1'b0;
    ResData    = '0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state_q)
      S_LOAD: begin
        SrcReady   = 1'b1;
        HostSel    = 1'b1;
        HostWrEn   = SrcValid;
        HostAddr   = wrap_addr(LOAD_BASE_A, idx_q);
        HostWrData = SrcData;
        Busy       = 1'b1;
      end
      S_START: begin
        DutStart = 1'b1;
        Busy     = 1'b1;
      end
      S_WAIT: begin
        Busy = 1'b1;
      end
      S_DRAIN: begin
        HostSel  = 1'b1;
        HostAddr = wrap_addr(RES_BASE_A, idx_q);
        ResValid = 1'b1;
        ResData  = HostRdData;
        Busy     = 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign TimedOut   = to_q;
  assign CycleCount = cyc_q;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_dut_host_sequencer.sv
module tb_dut_host_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       src_valid;
  logic [7:0] src_data;
  logic       res_ready;
  logic       go  [3];
  logic       ack [3];

  logic        srcready [3];
  logic        hostsel  [3];
  logic        wren     [3];
  logic        start    [3];
  logic        resvalid [3];
  logic        busy     [3];
  logic        done     [3];
  logic        tout     [3];
  logic [7:0]  addr     [3];
  logic [7:0]  wdata    [3];
  logic [7:0]  rddata   [3];
  logic [7:0]  resdata  [3];
  logic [15:0] cyc      [3];

  // Memory model: word at address a reads as a ^ 8'hA5.
  assign rddata[0] = addr[0] ^ 8'hA5;
  assign rddata[1] = addr[1] ^ 8'hA5;
  assign rddata[2] = addr[2] ^ 8'hA5;

  // Instance 0: main runs; 1: zero-length; 2: wrapping load base.
  dut_host_sequencer #(.AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(4), .RES_BASE(64),
    .RES_LEN(2), .START_CYC(2), .TIMEOUT(16)) u_a (
    .Clk(clk), .Reset(rst_n), .Go(go[0]), .SrcValid(src_valid), .SrcData(src_data),
    .SrcReady(srcready[0]), .HostSel(hostsel[0]), .HostWrEn(wren[0]), .HostAddr(addr[0]),
    .HostWrData(wdata[0]), .HostRdData(rddata[0]), .DutStart(start[0]), .DutAck(ack[0]),
    .ResValid(resvalid[0]), .ResData(resdata[0]), .ResReady(res_ready), .Busy(busy[0]),
    .Done(done[0]), .TimedOut(tout[0]), .CycleCount(cyc[0]));

  dut_host_sequencer #(.AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(0), .RES_BASE(64),
    .RES_LEN(0), .START_CYC(2), .TIMEOUT(16)) u_z (
    .Clk(clk), .Reset(rst_n), .Go(go[1]), .SrcValid(src_valid), .SrcData(src_data),
    .SrcReady(srcready[1]), .HostSel(hostsel[1]), .HostWrEn(wren[1]), .HostAddr(addr[1]),
    .HostWrData(wdata[1]), .HostRdData(rddata[1]), .DutStart(start[1]), .DutAck(ack[1]),
    .ResValid(resvalid[1]), .ResData(resdata[1]), .ResReady(res_ready), .Busy(busy[1]),
    .Done(done[1]), .TimedOut(tout[1]), .CycleCount(cyc[1]));

  dut_host_sequencer #(.AW(8), .DW(8), .LOAD_BASE(254), .LOAD_LEN(4), .RES_BASE(64),
    .RES_LEN(2), .START_CYC(2), .TIMEOUT(16)) u_w (
    .Clk(clk), .Reset(rst_n), .Go(go[2]), .SrcValid(src_valid), .SrcData(src_data),
    .SrcReady(srcready[2]), .HostSel(hostsel[2]), .HostWrEn(wren[2]), .HostAddr(addr[2]),
    .HostWrData(wdata[2]), .HostRdData(rddata[2]), .DutStart(start[2]), .DutAck(ack[2]),
    .ResValid(resvalid[2]), .ResData(resdata[2]), .ResReady(res_ready), .Busy(busy[2]),
    .Done(done[2]), .TimedOut(tout[2]), .CycleCount(cyc[2]));

  int sel;
  logic        m_srcready, m_hostsel, m_wren, m_start, m_resvalid, m_busy, m_done, m_tout;
  logic [7:0]  m_addr, m_wdata, m_resdata;
  logic [15:0] m_cyc;
  assign m_srcready = srcready[sel];
  assign m_hostsel  = hostsel[sel];
  assign m_wren     = wren[sel];
  assign m_start    = start[sel];
  assign m_resvalid = resvalid[sel];
  assign m_busy     = busy[sel];
  assign m_done     = done[sel];
  assign m_tout     = tout[sel];
  assign m_addr     = addr[sel];
  assign m_wdata    = wdata[sel];
  assign m_resdata  = resdata[sel];
  assign m_cyc      = cyc[sel];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr  [$];
  logic [7:0] exp_res [$];

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;
  int start_cnt = 0;
  int wr_cnt = 0;
  int wr_first = 0;
  int wr_last = 0;
  int res_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not as expected", name);
  endtask

  task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Monitor: pops the scoreboard whenever the selected DUT presents output.
  initial forever begin
    @(negedge clk);
    if (m_start) start_cnt++;
    if (m_wren) begin
      chk("wr_hostsel", 32'(m_hostsel), 32'd1);
      if (exp_wr.size() == 0) begin
        fail("unexpected_write");
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(m_addr), 32'(e.a));
        chk("wr_data", 32'(m_wdata), 32'(e.d));
      end
      if (wr_cnt == 0) wr_first = cycle;
      wr_last = cycle;
      wr_cnt++;
    end
    if (m_resvalid) begin
      if (exp_res.size() == 0) begin
        fail("unexpected_result");
      end else begin
        chk("res_data", 32'(m_resdata), 32'(exp_res[0]));
        if (res_ready) begin
          void'(exp_res.pop_front());
          res_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [31:0] words, input bit gaps);
    int i = 0;
    int phase = 0;
    int budget = 0;
    while (i < n && budget < 50) begin
      bit v;
      v = gaps ? (phase % 2 == 0) : 1'b1;
      phase++;
      src_valid = v;
      src_data  = v ? words[8*i +: 8] : 8'hFF;
      if (v && m_srcready) i++;
      step();
      budget++;
    end
    src_valid = 1'b0;
    if (i < n) fail("load_budget");
  endtask

  task automatic wait_release();
    int b = 0;
    while (!m_start && b < 20) begin step(); b++; end
    while (m_start && b < 20) begin step(); b++; end
    if (b >= 20) fail("start_budget");
  endtask

  task automatic drain(input bit hold);
    int k = 0;
    while (!m_done && k < 40) begin
      res_ready = hold ? (k >= 3) : 1'b1;
      k++;
      step();
    end
    res_ready = 1'b1;
    if (!m_done) fail("drain_budget");
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!m_done && n < 100) begin step(); n++; end
    if (!m_done) fail("done_budget");
  endtask

  // One run: Go, load 4 words, START, then Ack after ackdly WAIT cycles and
  // drain; ackdly < 0 returns in the first WAIT cycle without Ack.
  task automatic run(input int inst, input logic [31:0] words, input bit gaps,
                     input int ackdly, input bit hold);
    start_cnt = 0;
    wr_cnt    = 0;
    res_cnt   = 0;
    go[inst]  = 1'b1;
    step();
    go[inst]  = 1'b0;
    chk("go_to_load", 32'(m_srcready), 32'd1);
    chk("go_clears_timedout", 32'(m_tout), 32'd0);
    chk("go_clears_cyclecount", 32'(m_cyc), 32'd0);
    load(4, words, gaps);
    wait_release();
    if (ackdly >= 0) begin
      repeat (ackdly) step();
      ack[inst] = 1'b1;
      step();
      ack[inst] = 1'b0;
      drain(hold);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [3:0] exp_st;
    logic [3:0] exp_dn;
    rst_n = 1'b0; src_valid = 1'b0; src_data = 8'h00; res_ready = 1'b1; sel = 0;
    for (int i = 0; i < 3; i++) begin go[i] = 1'b0; ack[i] = 1'b0; end
    repeat (3) step();

    // Reset state
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_done", 32'(m_done), 0);
    chk("rst_timedout", 32'(m_tout), 0);
    chk("rst_cyclecount", 32'(m_cyc), 0);
    chk("rst_start", 32'(m_start), 0);
    chk("rst_hostsel", 32'(m_hostsel), 0);
    rst_n = 1'b1;
    step();

    // Basic run
    exp_w(8'd0, 8'h11); exp_w(8'd1, 8'h22); exp_w(8'd2, 8'h33); exp_w(8'd3, 8'h44);
    exp_res.push_back(8'hE5); exp_res.push_back(8'hE4);
    run(0, 32'h44332211, 1'b0, 10, 1'b0);
    chk("basic_start_cycles", start_cnt, 2);
    chk("basic_cyclecount", 32'(m_cyc), 10);
    chk("basic_timedout", 32'(m_tout), 0);
    chk("basic_done", 32'(m_done), 1);
    chk("basic_busy", 32'(m_busy), 0);
    chk("basic_writes", wr_cnt, 4);
    chk("basic_write_span", wr_last - wr_first, 3);
    chk("basic_results", res_cnt, 2);
    chk("basic_wr_left", exp_wr.size(), 0);
    chk("basic_res_left", exp_res.size(), 0);

    // Backpressure
    exp_w(8'd0, 8'h5A); exp_w(8'd1, 8'hA5); exp_w(8'd2, 8'h3C); exp_w(8'd3, 8'hC3);
    exp_res.push_back(8'hE5); exp_res.push_back(8'hE4);
    run(0, 32'hC33CA55A, 1'b1, 5, 1'b1);
    chk("bp_writes", wr_cnt, 4);
    chk("bp_write_span", wr_last - wr_first, 6);
    chk("bp_results", res_cnt, 2);
    chk("bp_cyclecount", 32'(m_cyc), 5);
    chk("bp_done", 32'(m_done), 1);

    // Timeout
    exp_w(8'd0, 8'h55); exp_w(8'd1, 8'h66); exp_w(8'd2, 8'h77); exp_w(8'd3, 8'h88);
    run(0, 32'h88776655, 1'b0, -1, 1'b0);
    wait_done(n);
    chk("to_wait_cycles", n, 16);
    chk("to_timedout", 32'(m_tout), 1);
    chk("to_cyclecount", 32'(m_cyc), 16);
    chk("to_done", 32'(m_done), 1);
    chk("to_no_results", res_cnt, 0);

    // Reset mid-WAIT
    exp_w(8'd0, 8'h01); exp_w(8'd1, 8'h02); exp_w(8'd2, 8'h03); exp_w(8'd3, 8'h04);
    run(0, 32'h04030201, 1'b0, -1, 1'b0);
    step(); step();
    chk("mid_cyclecount", 32'(m_cyc), 2);
    rst_n = 1'b0;
    go[0] = 1'b1;
    step();
    chk("mr_busy", 32'(m_busy), 0);
    chk("mr_done", 32'(m_done), 0);
    chk("mr_cyclecount", 32'(m_cyc), 0);
    chk("mr_start", 32'(m_start), 0);
    chk("mr_srcready", 32'(m_srcready), 0);
    chk("mr_hostsel", 32'(m_hostsel), 0);
    chk("mr_addr", 32'(m_addr), 0);
    chk("mr_resvalid", 32'(m_resvalid), 0);
    step();
    chk("mr_go_ignored", 32'(m_busy), 0);
    rst_n = 1'b1;
    go[0] = 1'b0;
    step();
    chk("mr_stay_idle", 32'(m_busy), 0);
    exp_w(8'd0, 8'hA1); exp_w(8'd1, 8'hB2); exp_w(8'd2, 8'hC3); exp_w(8'd3, 8'hD4);
    exp_res.push_back(8'hE5); exp_res.push_back(8'hE4);
    run(0, 32'hD4C3B2A1, 1'b0, 3, 1'b0);
    chk("fresh_cyclecount", 32'(m_cyc), 3);
    chk("fresh_start_cycles", start_cnt, 2);
    chk("fresh_results", res_cnt, 2);
    chk("fresh_done", 32'(m_done), 1);

    // Zero-length
    sel = 1;
    ack[1] = 1'b1;
    start_cnt = 0; wr_cnt = 0; res_cnt = 0;
    exp_st = 4'b0011;
    exp_dn = 4'b1000;
    go[1] = 1'b1;
    step();
    go[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("zero_start_c%0d", k), 32'(m_start), 32'(exp_st[k]));
      chk($sformatf("zero_done_c%0d", k), 32'(m_done), 32'(exp_dn[k]));
      if (k < 3) step();
    end
    chk("zero_cyclecount", 32'(m_cyc), 0);
    chk("zero_start_cycles", start_cnt, 2);
    chk("zero_writes", wr_cnt, 0);
    chk("zero_results", res_cnt, 0);
    ack[1] = 1'b0;

    // Wrapping base, re-run from DONE
    sel = 2;
    exp_w(8'd254, 8'h12); exp_w(8'd255, 8'h34); exp_w(8'd0, 8'h56); exp_w(8'd1, 8'h78);
    run(2, 32'h78563412, 1'b0, -1, 1'b0);
    wait_done(n);
    chk("wrap_timedout", 32'(m_tout), 1);
    chk("wrap_to_cyclecount", 32'(m_cyc), 16);
    exp_w(8'd254, 8'h9A); exp_w(8'd255, 8'hBC); exp_w(8'd0, 8'hDE); exp_w(8'd1, 8'hF0);
    exp_res.push_back(8'hE5); exp_res.push_back(8'hE4);
    run(2, 32'hF0DEBC9A, 1'b0, 2, 1'b0);
    chk("rerun_cyclecount", 32'(m_cyc), 2);
    chk("rerun_timedout", 32'(m_tout), 0);
    chk("rerun_done", 32'(m_done), 1);
    chk("rerun_writes", wr_cnt, 4);
    chk("rerun_results", res_cnt, 2);
    chk("rerun_wr_left", exp_wr.size(), 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dut_host_sequencer.md
# dut_host_sequencer

Host-side initiator for the processor's Start/Ack program handshake. It loads an input block from a source stream into data memory through a host write port, then pulses the processor's `Start`. It then waits for `Ack` while counting cycles, and streams a result region of data memory back out. It sits beside the processor top level in the test/integration harness and owns the data-memory port whenever `HostSel` is high.

## Interface
Parameters:
- `AW`, default 8: data-memory address width.
- `DW`, default 8: data word width.
- `LOAD_BASE`, default 0: first memory address written during load.
- `LOAD_LEN`, default 64: number of words loaded; 0 is legal.
- `RES_BASE`, default 64: first memory address read during drain.
- `RES_LEN`, default 64: number of words drained; 0 is legal.
- `START_CYC`, default 2: cycles `DutStart` is held high; must be ≥ 1.
- `TIMEOUT`, default 4096: maximum WAIT cycles before abort; must be ≥ 1.

Ports:
- `Clk` input 1: clock, posedge only.
- `Reset` input 1: **synchronous, active-low** reset (0 = reset).
- `Go` input 1: begin a run; sampled in IDLE and DONE only.
- `SrcValid` input 1: source word valid.
- `SrcData` input DW: source word.
- `SrcReady` output 1: sequencer accepts a source word.
- `HostSel` output 1: host owns the data-memory port.
- `HostWrEn` output 1: memory write enable.
- `HostAddr` output AW: memory address.
- `HostWrData` output DW: memory write data.
- `HostRdData` input DW: combinational memory read data at `HostAddr`.
- `DutStart` output 1: processor `Start`.
- `DutAck` input 1: processor `Ack`.
- `ResValid` output 1: result word valid.
- `ResData` output DW: result word.
- `ResReady` input 1: sink accepts the result word.
- `Busy` output 1: state is not IDLE or DONE.
- `Done` output 1: state is DONE.
- `TimedOut` output 1: the last run aborted on timeout.
- `CycleCount` output 16: DUT cycles counted in the last WAIT.

## Operation
- States: IDLE, LOAD, START, WAIT, DRAIN, DONE. A single index counter `idx` (width ≥ log2 of max(LOAD_LEN, RES_LEN) + 1) is shared by LOAD and DRAIN.
- **IDLE**
  - `Go`=1 → LOAD if LOAD_LEN>0, else START.
  - On that transition: `idx`←0, `TimedOut`←0, `CycleCount`←0.
- **LOAD**
  - `SrcReady`=1 and `HostSel`=1.
  - `HostWrEn`=`SrcValid`, `HostAddr`=LOAD_BASE+`idx` (mod 2^AW), `HostWrData`=`SrcData`; all combinational.
  - Each handshake (`SrcValid`&`SrcReady`) increments `idx`.
  - The handshake with `idx`=LOAD_LEN−1 → START.
  - Gaps in `SrcValid` stall without side effects.
- **START**
  - `DutStart`=1 for exactly START_CYC cycles.
  - `HostSel`=0, so the processor owns memory.
  - Then → WAIT with the counter cleared.
- **WAIT**
  - `DutStart`=0, `HostSel`=0.
  - `DutAck`=1 → DRAIN (or DONE if RES_LEN=0), `idx`←0, `CycleCount` frozen.
  - `DutAck`=0 → `CycleCount` increments, saturating at 16'hFFFF.
  - If `DutAck`=0 on the TIMEOUT-th WAIT cycle → `TimedOut`←1, go to DONE, and skip DRAIN.
  - `DutAck` is ignored in every other state.
- **DRAIN**
  - `HostSel`=1, `HostWrEn`=0, `HostAddr`=RES_BASE+`idx` (mod 2^AW).
  - `ResValid`=1, `ResData`=`HostRdData` (combinational).
  - Each `ResValid`&`ResReady` increments `idx`; the handshake at `idx`=RES_LEN−1 → DONE.
  - `ResData` is stable while `ResReady`=0.
- **DONE**
  - `Done`=1 and all strobes are 0.
  - `CycleCount` and `TimedOut` are held.
  - `Go`=1 → same entry as from IDLE.
- Outside LOAD: `SrcReady`=0, `HostWrEn`=0.
- Outside DRAIN: `ResValid`=0.
- When `HostSel`=0, `HostAddr` and `HostWrData` are 0.

## Timing
- All state, `idx`, and counters are registered on posedge `Clk`.
- Strobes are decoded combinationally from state plus inputs; no input-to-output path exists other than the LOAD and DRAIN pass-throughs listed above.
- Reset (`Reset`=0 at posedge) forces from any state, mid-run included:
  - state → IDLE;
  - `idx`, `CycleCount` → 0; `TimedOut` → 0;
  - all outputs → 0 in the following cycle.
- Reset dominates `Go`.
- Latencies:
  - `Go` → first LOAD cycle: 1 cycle.
  - Last load handshake → `DutStart` high: next cycle.
  - `DutStart` is high for START_CYC cycles.
- `CycleCount` equals the number of WAIT cycles with `DutAck`=0. `DutAck` already high in the first WAIT cycle gives `CycleCount`=0.
- Throughput: 1 word/cycle in LOAD and DRAIN when the partner is always ready.

## Test plan
- **Basic run.** LOAD_LEN=4, RES_LEN=2; source 8'h11..8'h44 back-to-back; DUT model raises `Ack` after 10 WAIT cycles.
  - Writes to addresses 0..3 on consecutive cycles.
  - `DutStart` high 2 cycles.
  - `CycleCount`=10.
  - `ResData` = mem[64], mem[65].
  - `Done`=1.
- **Backpressure.** `SrcValid` toggles 1,0,1,0 and `ResReady` is low for 3 cycles.
  - No write occurs in gap cycles.
  - `ResData` is held constant while `ResReady`=0.
  - Word order is preserved.
- **Timeout.** TIMEOUT=16, `Ack` never rises.
  - After exactly 16 WAIT cycles: `TimedOut`=1, `Done`=1, `CycleCount`=16.
  - `ResValid` never asserts.
- **Zero-length.** LOAD_LEN=0, RES_LEN=0, `Ack` already high.
  - Sequence is IDLE→START(2)→WAIT(1)→DONE.
  - `CycleCount`=0.
  - No `HostWrEn` and no `ResValid`.
- **Reset mid-WAIT.** Assert `Reset`=0 while `DutStart` was just released.
  - Next cycle: IDLE, all outputs 0.
  - `Go` is ignored while `Reset`=0.
  - A subsequent run behaves as a fresh run.
- **Re-run from DONE.** `Go` in DONE; `LOAD_BASE` wraps (LOAD_BASE=254, LOAD_LEN=4).
  - Writes go to 254, 255, 0, 1.
  - `TimedOut` clears on restart.
